// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand path: sizes, beat counts and
// the loader state encoding decoded by the controller and display.
package matrix_pkg;

   localparam int DATA_W  = 8;
   localparam int A_DIM   = 4;
   localparam int B_DIM   = 3;
   localparam int A_BEATS = A_DIM * A_DIM;
   localparam int B_BEATS = B_DIM * B_DIM;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_A = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_ARM    = 3'd3,
      ST_HOLD   = 3'd4,
      ST_CHK    = 3'd5
   } loader_state_e;

   function automatic logic state_ready(input loader_state_e s);
      logic r;
      r = 1'b0;
      unique case (s)
         ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_CHK: r = 1'b1;
         default:                               r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/matrix_loader.sv
// Byte-serial A/B operand loader; pulses run_o once a full frame is stored.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module matrix_loader #(
   parameter int DATA_W = matrix_pkg::DATA_W,
   parameter int A_DIM  = matrix_pkg::A_DIM,
   parameter int B_DIM  = matrix_pkg::B_DIM
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_W-1:0]               data_i,
   input  logic                            valid_i,
   output logic                            ready_o,
   input  logic                            done_i,
   output logic [A_DIM*A_DIM*DATA_W-1:0]   a_mat_o,
   output logic [B_DIM*B_DIM*DATA_W-1:0]   b_mat_o,
   output logic                            run_o,
   output logic                            busy_o,
   output logic [2:0]                      state_o,
   output logic                            err_o
);

   import matrix_pkg::*;

   localparam int A_N   = A_DIM * A_DIM;
   localparam int B_N   = B_DIM * B_DIM;
   localparam int MAX_N = (A_N > B_N) ? A_N : B_N;
   localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   loader_state_e       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    wr_idx;
   logic [DATA_W-1:0]   chk_q, chk_d;
   logic                err_q, err_d;
   logic                ready_q, run_q, busy_q;
   logic                a_we, b_we;
   logic                beat;
   logic [DATA_W-1:0]   a_q [A_N];
   logic [DATA_W-1:0]   b_q [B_N];

   assign beat = valid_i & ready_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chk_d   = chk_q;
      err_d   = err_q;
      a_we    = 1'b0;
      b_we    = 1'b0;
      wr_idx  = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (beat) begin
               a_we    = 1'b1;
               wr_idx  = '0;
               cnt_d   = CNT_W'(1);
               chk_d   = data_i;
               state_d = ST_LOAD_A;
            end
         end
         ST_LOAD_A: begin
            if (beat) begin
               a_we  = 1'b1;
               chk_d = chk_q ^ data_i;
               if (cnt_q == CNT_W'(A_N - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_LOAD_B;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_LOAD_B: begin
            if (beat) begin
               b_we  = 1'b1;
               chk_d = chk_q ^ data_i;
               if (cnt_q == CNT_W'(B_N - 1)) begin
                  cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_ARM;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_ARM: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (done_i) begin
               state_d = ST_IDLE;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (beat) begin
               if (data_i == chk_q) begin
                  state_d = ST_ARM;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
`endif
         default: begin
            // Illegal encodings drop any partial frame.
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         chk_q   <= '0;
         ready_q <= 1'b0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chk_q   <= chk_d;
         ready_q <= state_ready(state_d);
         run_q   <= (state_d == ST_ARM);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < A_N; i++) begin
            a_q[i] <= '0;
         end
      end else if (a_we) begin
         a_q[wr_idx] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < B_N; i++) begin
            b_q[i] <= '0;
         end
      end else if (b_we) begin
         b_q[wr_idx] <= data_i;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign err_q = 1'b0;
`endif

   for (genvar i = 0; i < A_N; i++) begin : g_apack
      assign a_mat_o[i*DATA_W +: DATA_W] = a_q[i];
   end

   for (genvar i = 0; i < B_N; i++) begin : g_bpack
      assign b_mat_o[i*DATA_W +: DATA_W] = b_q[i];
   end

   assign ready_o = ready_q;
   assign run_o   = run_q;
   assign busy_o  = busy_q;
   assign err_o   = err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized bench for matrix_loader against a frame-level reference model.
// Build with LOADER_CHECKSUM_EN to also exercise the checksum byte.
module tb_matrix_loader;

   import matrix_pkg::*;

   localparam int DW = matrix_pkg::DATA_W;
   localparam int AN = A_BEATS;
   localparam int BN = B_BEATS;
`ifdef LOADER_CHECKSUM_EN
   localparam int FN = AN + BN + 1;
`else
   localparam int FN = AN + BN;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW-1:0]     data;
   logic              valid;
   logic              ready;
   logic              done;
   logic [AN*DW-1:0]  a_mat;
   logic [BN*DW-1:0]  b_mat;
   logic              run;
   logic              busy;
   logic [2:0]        state;
   logic              err;

   int n_tests = 0;
   int n_fail  = 0;
   int run_cnt = 0;
   int frames  = 0;
   logic exp_err = 1'b0;

   logic [DW-1:0] exp_a [AN];
   logic [DW-1:0] exp_b [BN];
   logic [DW-1:0] frame_q [$];

   matrix_loader dut (
      .clk     (clk),
      .reset   (rst_n),
      .data_i  (data),
      .valid_i (valid),
      .ready_o (ready),
      .done_i  (done),
      .a_mat_o (a_mat),
      .b_mat_o (b_mat),
      .run_o   (run),
      .busy_o  (busy),
      .state_o (state),
      .err_o   (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (run) run_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [AN*DW-1:0] pack_a();
      logic [AN*DW-1:0] v;
      for (int i = 0; i < AN; i++) v[i*DW +: DW] = exp_a[i];
      return v;
   endfunction

   function automatic logic [BN*DW-1:0] pack_b();
      logic [BN*DW-1:0] v;
      for (int i = 0; i < BN; i++) v[i*DW +: DW] = exp_b[i];
      return v;
   endfunction

   task automatic make_frame(input int kind, input logic [DW-1:0] base);
      logic [DW-1:0] x;
      frame_q.delete();
      x = '0;
      for (int i = 0; i < AN + BN; i++) begin
         frame_q.push_back(kind == 0 ? base + DW'(i) : DW'($urandom));
         x ^= frame_q[i];
      end
`ifdef LOADER_CHECKSUM_EN
      frame_q.push_back(x);
`endif
   endtask

   task automatic clear_model();
      for (int i = 0; i < AN; i++) exp_a[i] = '0;
      for (int i = 0; i < BN; i++) exp_b[i] = '0;
   endtask

   task automatic commit_model();
      for (int i = 0; i < AN; i++) exp_a[i] = frame_q[i];
      for (int i = 0; i < BN; i++) exp_b[i] = frame_q[AN + i];
   endtask

   // Entered and left on a negedge; leaves just after the n-th beat.
   task automatic send_beats(input int n, input int gap_every,
                             input int gap_len, input int done_at);
      int guard;
      for (int i = 0; i < n; i++) begin
         data  = frame_q[i];
         valid = 1'b1;
         done  = (i == done_at);
         guard = 0;
         while (!ready && guard < 40) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 40) begin
            check("ready_timeout", 0, 1);
            valid = 1'b0;
            done  = 1'b0;
            return;
         end
         @(negedge clk);
         valid = 1'b0;
         done  = 1'b0;
         if (gap_every > 0 && (i + 1) % gap_every == 0 && i != n - 1)
            repeat (gap_len) @(negedge clk);
      end
   endtask

   task automatic finish_frame(input string tag);
      commit_model();
      frames++;
      check({tag, "_run_hi"}, run, 1);
      check({tag, "_st_arm"}, state, 3);
      @(negedge clk);
      check({tag, "_run_lo"}, run, 0);
      check({tag, "_st_hold"}, state, 4);
      check({tag, "_rdy_lo"}, ready, 0);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_a"}, a_mat, pack_a());
      check({tag, "_b"}, b_mat, pack_b());
      check({tag, "_npulse"}, run_cnt, frames);
   endtask

   task automatic release_hold();
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("rel_idle", state, 0);
      check("rel_busy", busy, 0);
      check("rel_rdy", ready, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a"}, a_mat, 0);
      check({tag, "_b"}, b_mat, 0);
      check({tag, "_run"}, run, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_rdy"}, ready, 0);
      check({tag, "_st"}, state, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      done  = 1'b0;
      data  = '0;
      clear_model();
      repeat (3) @(negedge clk);
      check_zero("rst");
      rst_n = 1'b1;

      make_frame(0, 8'd1);
      send_beats(FN, 0, 0, -1);
      finish_frame("seq");
      check("a11", a_mat[7:0], 8'd1);
      check("a44", a_mat[127:120], 8'd16);
      check("b11", b_mat[7:0], 8'd17);
      check("b33", b_mat[71:64], 8'd25);

      release_hold();
      clear_model();
      make_frame(0, 8'd1);
      send_beats(FN, 4, 3, -1);
      finish_frame("gap");

      for (int i = 0; i < 10; i++) begin
         data  = 8'hFF;
         valid = 1'b1;
         @(negedge clk);
         check("hold_rdy", ready, 0);
         check("hold_a", a_mat, pack_a());
         check("hold_b", b_mat, pack_b());
      end
      valid = 1'b0;
      release_hold();
      make_frame(0, 8'h80);
      send_beats(FN, 0, 0, -1);
      finish_frame("ovw");
      check("ovw_a11", a_mat[7:0], 8'h80);

      release_hold();
      make_frame(1, 8'd0);
      send_beats(10, 0, 0, -1);
      #2 rst_n = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      make_frame(0, 8'd1);
      send_beats(FN, 0, 0, -1);
      finish_frame("postrst");

      release_hold();
      make_frame(1, 8'd0);
      send_beats(FN, 0, 0, 5);
      finish_frame("done_la");

      for (int k = 0; k < 5; k++) begin
         release_hold();
         make_frame(1, 8'd0);
         send_beats(FN, $urandom_range(1, 5), $urandom_range(0, 4),
                    $urandom_range(1, 20));
         finish_frame("rnd");
      end

`ifdef LOADER_CHECKSUM_EN
      release_hold();
      make_frame(0, 8'd1);
      check("xor_ref", frame_q[FN-1], 8'h01);
      frame_q[FN-1] = 8'h00;
      send_beats(FN, 0, 0, -1);
      commit_model();
      exp_err = 1'b1;
      check("bad_err", err, 1);
      check("bad_run", run, 0);
      check("bad_st", state, 0);
      @(negedge clk);
      check("bad_npulse", run_cnt, frames);
      check("bad_a", a_mat, pack_a());
      check("bad_b", b_mat, pack_b());
      make_frame(1, 8'd0);
      send_beats(FN, 0, 0, -1);
      finish_frame("sticky");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
